// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha block core: word type, constants,
// quarter-round index tables, FSM state encoding and a rotate helper.
package chacha_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    // "expand 32-byte k"
    localparam word_t SIGMA [4] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    localparam logic [3:0] COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam logic [3:0] DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round.
// Ports: a_i..d_i input words, a_o..d_o updated words.
module chacha_qr
    import chacha_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    input  word_t c_i,
    input  word_t d_i,
    output word_t a_o,
    output word_t b_o,
    output word_t c_o,
    output word_t d_o
);

    word_t a1, b1, c1, d1;
    word_t a2, b2, c2, d2;

    always_comb begin
        a1 = a_i + b_i;
        d1 = rotl(d_i ^ a1, 16);
        c1 = c_i + d1;
        b1 = rotl(b_i ^ c1, 12);
        a2 = a1 + b1;
        d2 = rotl(d1 ^ a2, 8);
        c2 = c1 + d2;
        b2 = rotl(b1 ^ c2, 7);
    end

    assign a_o = a2;
    assign b_o = b2;
    assign c_o = c2;
    assign d_o = d2;

endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function with LANES quarter rounds per cycle.
// Ports: clk/rst, in_valid/in_ready + key/counter/nonce job input,
//        out_valid/out_ready + out_block keystream output, busy status.
module chacha_block_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int LANES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);

    localparam int STEPS = 4 / LANES;
    localparam logic [1:0] LAST_STEP  = 2'(STEPS - 1);
    localparam logic [4:0] LAST_LAYER = 5'(ROUNDS - 1);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
    end
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("chacha_block_core: LANES must be 1, 2 or 4");
    end

    state_t     state_q;
    word_t      work_q [16];
    word_t      save_q [16];
    logic [4:0] layer_q;
    logic [1:0] step_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       busy_q;

    word_t      init_d [16];
    logic [3:0] idx    [LANES][4];
    word_t      qin    [LANES][4];
    word_t      qout   [LANES][4];

    // Quarter-round number handled by lane l in the current step.
    function automatic logic [1:0] qsel(input logic [1:0] step, input int l);
        return 2'(int'(step) * LANES + l);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) init_d[i] = SIGMA[i];
        for (int i = 0; i < 8; i++) init_d[4 + i] = key[32 * i +: 32];
        init_d[12] = counter;
        for (int i = 0; i < 3; i++) init_d[13 + i] = nonce[32 * i +: 32];
    end

    // Lanes of one step touch disjoint words, so they run in parallel
    // and write back independently.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int p = 0; p < 4; p++) begin
                idx[l][p] = layer_q[0] ? DIAG_IDX[qsel(step_q, l)][p]
                                       : COL_IDX[qsel(step_q, l)][p];
                qin[l][p] = work_q[idx[l][p]];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        chacha_qr u_qr (
            .a_i (qin[l][0]),
            .b_i (qin[l][1]),
            .c_i (qin[l][2]),
            .d_i (qin[l][3]),
            .a_o (qout[l][0]),
            .b_o (qout[l][1]),
            .c_o (qout[l][2]),
            .d_o (qout[l][3])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            layer_q     <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                work_q[k] <= '0;
                save_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 16; k++) begin
                            work_q[k] <= init_d[k];
                            save_q[k] <= init_d[k];
                        end
                        layer_q    <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    for (int l = 0; l < LANES; l++) begin
                        for (int p = 0; p < 4; p++) begin
                            work_q[idx[l][p]] <= qout[l][p];
                        end
                    end
                    if (step_q == LAST_STEP) begin
                        step_q <= '0;
                        if (layer_q == LAST_LAYER) begin
                            layer_q <= '0;
                            state_q <= ST_FINAL;
                        end else begin
                            layer_q <= layer_q + 5'd1;
                        end
                    end else begin
                        step_q <= step_q + 2'd1;
                    end
                end
                ST_FINAL: begin
                    for (int k = 0; k < 16; k++) begin
                        work_q[k] <= work_q[k] + save_q[k];
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    for (genvar k = 0; k < 16; k++) begin : g_out
        assign out_block[32 * k +: 32] = work_q[k];
    end

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core against a software ChaCha model.
// Four core configurations plus a standalone quarter round are exercised.
module tb_chacha_block_core;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key;
    logic [31:0]  ctr;
    logic [95:0]  nonce;

    logic iv_a, ir_a, ov_a, or_a, bz_a;
    logic iv_b, ir_b, ov_b, or_b, bz_b;
    logic iv_c, ir_c, ov_c, or_c, bz_c;
    logic iv_d, ir_d, ov_d, or_d, bz_d;
    logic [511:0] ob_a, ob_b, ob_c, ob_d;

    logic [31:0] qa, qb, qc, qd, ya, yb, yc, yd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chacha_block_core #(.ROUNDS(20), .LANES(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a),
        .key(key), .counter(ctr), .nonce(nonce),
        .out_valid(ov_a), .out_ready(or_a), .out_block(ob_a), .busy(bz_a)
    );
    chacha_block_core #(.ROUNDS(20), .LANES(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b),
        .key(key), .counter(ctr), .nonce(nonce),
        .out_valid(ov_b), .out_ready(or_b), .out_block(ob_b), .busy(bz_b)
    );
    chacha_block_core #(.ROUNDS(20), .LANES(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c),
        .key(key), .counter(ctr), .nonce(nonce),
        .out_valid(ov_c), .out_ready(or_c), .out_block(ob_c), .busy(bz_c)
    );
    chacha_block_core #(.ROUNDS(8), .LANES(2)) dut_d (
        .clk(clk), .rst(rst), .in_valid(iv_d), .in_ready(ir_d),
        .key(key), .counter(ctr), .nonce(nonce),
        .out_valid(ov_d), .out_ready(or_d), .out_block(ob_d), .busy(bz_d)
    );

    chacha_qr u_qr (
        .a_i(qa), .b_i(qb), .c_i(qc), .d_i(qd),
        .a_o(ya), .b_o(yb), .c_o(yc), .d_o(yd)
    );

    function automatic logic [31:0] rl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Straightforward software ChaCha block function.
    function automatic logic [511:0] model(input logic [255:0] k,
                                           input logic [31:0] c,
                                           input logic [95:0] n,
                                           input int rounds);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [31:0] a, b, cc, d;
        logic [511:0] res;
        int ib, ic, id;
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32 * i +: 32];
        x = s;
        for (int r = 0; r < rounds; r++) begin
            for (int q = 0; q < 4; q++) begin
                if (r % 2 == 0) begin
                    ib = 4 + q; ic = 8 + q; id = 12 + q;
                end else begin
                    ib = 4 + (q + 1) % 4;
                    ic = 8 + (q + 2) % 4;
                    id = 12 + (q + 3) % 4;
                end
                a = x[q]; b = x[ib]; cc = x[ic]; d = x[id];
                a = a + b;  d = rl(d ^ a, 16);
                cc = cc + d; b = rl(b ^ cc, 12);
                a = a + b;  d = rl(d ^ a, 8);
                cc = cc + d; b = rl(b ^ cc, 7);
                x[q] = a; x[ib] = b; x[ic] = cc; x[id] = d;
            end
        end
        for (int i = 0; i < 16; i++) res[32 * i +: 32] = x[i] + s[i];
        return res;
    endfunction

    function automatic logic [255:0] rfc_key();
        logic [255:0] k;
        for (int b = 0; b < 32; b++) k[8 * b +: 8] = 8'(b);
        return k;
    endfunction

    localparam logic [95:0] RFC_NONCE = {32'h0, 32'h4a000000, 32'h09000000};

    function automatic logic [255:0] rnd_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom();
        return k;
    endfunction

    function automatic logic [95:0] rnd_nonce();
        logic [95:0] n;
        for (int i = 0; i < 3; i++) n[32 * i +: 32] = $urandom();
        return n;
    endfunction

    // Drives one job into dut_a with out_ready high; starts and ends at a
    // negedge with the core idle. lat=200 marks a timeout.
    task automatic run_job(input logic [255:0] k, input logic [31:0] c,
                           input logic [95:0] n,
                           output logic [511:0] blk, output int lat);
        key = k; ctr = c; nonce = n;
        iv_a = 1'b1; or_a = 1'b1;
        @(negedge clk);
        iv_a = 1'b0;
        lat = 0;
        while (ov_a !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        blk = ob_a;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv_a = 0; iv_b = 0; iv_c = 0; iv_d = 0;
        or_a = 1; or_b = 1; or_c = 1; or_d = 1;
        key = '0; ctr = '0; nonce = '0;
        qa = '0; qb = '0; qc = '0; qd = '0;
        repeat (3) @(negedge clk);
        total++;
        if (ir_a !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=1", ir_a);
        end
        total++;
        if (ov_a !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b exp=0", ov_a);
        end
        total++;
        if (bz_a !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", bz_a);
        end
        total++;
        if (ob_a !== '0) begin
            bad++; $display("FAIL reset_out_block got=%h exp=0", ob_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_qr();
        logic [127:0] got;
        logic [127:0] exp;
        qa = 32'h11111111; qb = 32'h01020304;
        qc = 32'h9b8d6f43; qd = 32'h01234567;
        #1;
        got = {ya, yb, yc, yd};
        exp = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL qr_vector got=%h exp=%h", got, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_vector();
        logic [511:0] blk;
        logic [511:0] exp;
        int lat;
        exp = model(rfc_key(), 32'd1, RFC_NONCE, 20);
        run_job(rfc_key(), 32'd1, RFC_NONCE, blk, lat);
        total++;
        if (lat !== 21) begin
            bad++; $display("FAIL vec_latency got=%0d exp=21", lat);
        end
        total++;
        if (blk[31:0] !== 32'he4e7f110) begin
            bad++; $display("FAIL vec_word0 got=%h exp=e4e7f110", blk[31:0]);
        end
        total++;
        if (blk[511:480] !== 32'h4e3c50a2) begin
            bad++; $display("FAIL vec_word15 got=%h exp=4e3c50a2", blk[511:480]);
        end
        total++;
        if (blk !== exp) begin
            bad++; $display("FAIL vec_block got=%h exp=%h", blk, exp);
        end
        total++;
        if (ir_a !== 1'b1) begin
            bad++; $display("FAIL vec_idle_after got=%b exp=1", ir_a);
        end
    endtask

    task automatic test_lanes();
        int lat [4];
        bit seen [4];
        logic [511:0] blk [4];
        logic [511:0] exp [4];
        int exp_lat [4];
        logic [3:0] ovs;
        logic [511:0] obs [4];
        key = rfc_key(); ctr = 32'd1; nonce = RFC_NONCE;
        exp[0] = model(key, ctr, nonce, 20);
        exp[1] = exp[0];
        exp[2] = exp[0];
        exp[3] = model(key, ctr, nonce, 8);
        exp_lat[0] = 21; exp_lat[1] = 41; exp_lat[2] = 81; exp_lat[3] = 17;
        for (int i = 0; i < 4; i++) begin
            lat[i] = 0; seen[i] = 0; blk[i] = '0;
        end
        iv_a = 1; iv_b = 1; iv_c = 1; iv_d = 1;
        or_a = 1; or_b = 1; or_c = 1; or_d = 1;
        @(negedge clk);
        iv_a = 0; iv_b = 0; iv_c = 0; iv_d = 0;
        total++;
        if (bz_a !== 1'b1 || ir_a !== 1'b0) begin
            bad++;
            $display("FAIL lanes_accept busy=%b in_ready=%b exp busy=1 in_ready=0",
                     bz_a, ir_a);
        end
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            ovs = {ov_d, ov_c, ov_b, ov_a};
            obs[0] = ob_a; obs[1] = ob_b; obs[2] = ob_c; obs[3] = ob_d;
            for (int i = 0; i < 4; i++) begin
                if (ovs[i] === 1'b1 && !seen[i]) begin
                    seen[i] = 1; lat[i] = cyc; blk[i] = obs[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (lat[i] !== exp_lat[i]) begin
                bad++;
                $display("FAIL lanes_latency dut=%0d got=%0d exp=%0d",
                         i, lat[i], exp_lat[i]);
            end
            total++;
            if (blk[i] !== exp[i]) begin
                bad++;
                $display("FAIL lanes_block dut=%0d got=%h exp=%h", i, blk[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] held;
        logic [511:0] exp;
        logic [511:0] blk;
        int lat;
        bit stable;
        key = rnd_key(); ctr = $urandom(); nonce = rnd_nonce();
        exp = model(key, ctr, nonce, 20);
        iv_a = 1; or_a = 0;
        @(negedge clk);
        iv_a = 0;
        lat = 0;
        while (ov_a !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        held = ob_a;
        total++;
        if (held !== exp) begin
            bad++; $display("FAIL bp_block got=%h exp=%h", held, exp);
        end
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (ov_a !== 1'b1 || ir_a !== 1'b0 || ob_a !== held) stable = 0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_hold got out_valid=%b in_ready=%b exp 1/0 with constant block",
                     ov_a, ir_a);
        end
        // Offer a new job in the release cycle: it must not be taken yet.
        key = rnd_key(); ctr = $urandom(); nonce = rnd_nonce();
        exp = model(key, ctr, nonce, 20);
        or_a = 1; iv_a = 1;
        @(negedge clk);
        total++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1 || bz_a !== 1'b0) begin
            bad++;
            $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0",
                     ov_a, ir_a, bz_a);
        end
        @(negedge clk);
        iv_a = 0;
        total++;
        if (bz_a !== 1'b1) begin
            bad++; $display("FAIL bp_next_accept busy=%b exp=1", bz_a);
        end
        lat = 0;
        while (ov_a !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        blk = ob_a;
        total++;
        if (lat !== 21 || blk !== exp) begin
            bad++;
            $display("FAIL bp_second_job lat=%0d exp=21 got=%h exp=%h", lat, blk, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [511:0] blk;
        logic [511:0] exp;
        int lat;
        bit fired;
        key = rnd_key(); ctr = $urandom(); nonce = rnd_nonce();
        iv_a = 1; or_a = 1;
        @(negedge clk);
        iv_a = 0;
        repeat (6) @(negedge clk);
        rst = 1;
        #1;
        total++;
        if (ov_a !== 1'b0 || bz_a !== 1'b0 || ir_a !== 1'b1 || ob_a !== '0) begin
            bad++;
            $display("FAIL rst_mid_async out_valid=%b busy=%b in_ready=%b block=%h exp 0/0/1/0",
                     ov_a, bz_a, ir_a, ob_a);
        end
        @(negedge clk);
        rst = 0;
        fired = 0;
        repeat (30) begin
            @(negedge clk);
            if (ov_a !== 1'b0 || bz_a !== 1'b0) fired = 1;
        end
        total++;
        if (fired) begin
            bad++; $display("FAIL rst_mid_discard got activity exp=none");
        end
        // Accept on the first edge after a reset release.
        rst = 1;
        @(negedge clk);
        rst = 0;
        exp = model(rfc_key(), 32'd1, RFC_NONCE, 20);
        run_job(rfc_key(), 32'd1, RFC_NONCE, blk, lat);
        total++;
        if (lat !== 21 || blk !== exp) begin
            bad++;
            $display("FAIL rst_mid_next lat=%0d exp=21 got=%h exp=%h", lat, blk, exp);
        end
    endtask

    task automatic test_counter_wrap();
        logic [511:0] exp;
        logic [511:0] blk;
        int lat;
        bit fired;
        key = rfc_key(); ctr = 32'hffffffff; nonce = RFC_NONCE;
        exp = model(rfc_key(), 32'hffffffff, RFC_NONCE, 20);
        iv_a = 1; or_a = 1;
        @(negedge clk);
        lat = 0;
        while (ov_a !== 1'b1 && lat < 200) begin
            iv_a = 1'($urandom());
            key = rnd_key(); ctr = $urandom(); nonce = rnd_nonce();
            @(negedge clk);
            lat++;
        end
        iv_a = 0;
        blk = ob_a;
        total++;
        if (lat !== 21) begin
            bad++; $display("FAIL wrap_latency got=%0d exp=21", lat);
        end
        total++;
        if (blk !== exp) begin
            bad++; $display("FAIL wrap_block got=%h exp=%h", blk, exp);
        end
        fired = 0;
        repeat (30) begin
            @(negedge clk);
            if (ov_a !== 1'b0 || bz_a !== 1'b0) fired = 1;
        end
        total++;
        if (fired) begin
            bad++; $display("FAIL wrap_no_queue got activity exp=none");
        end
    endtask

    task automatic test_random();
        logic [511:0] exp;
        logic [511:0] held;
        int lat;
        int wait_n;
        bit ok;
        for (int j = 0; j < 6; j++) begin
            key = rnd_key(); ctr = $urandom(); nonce = rnd_nonce();
            exp = model(key, ctr, nonce, 20);
            iv_a = 1; or_a = 1'($urandom());
            @(negedge clk);
            iv_a = 0;
            lat = 0;
            while (ov_a !== 1'b1 && lat < 200) begin
                or_a = 1'($urandom());
                @(negedge clk);
                lat++;
            end
            held = ob_a;
            total++;
            if (lat !== 21 || held !== exp) begin
                bad++;
                $display("FAIL rand_job%0d lat=%0d exp=21 got=%h exp=%h",
                         j, lat, held, exp);
            end
            ok = 1;
            wait_n = 0;
            while (ov_a === 1'b1 && wait_n < 40) begin
                or_a = (wait_n > 20) ? 1'b1 : 1'($urandom());
                @(negedge clk);
                if (ov_a === 1'b1 && ob_a !== held) ok = 0;
                wait_n++;
            end
            total++;
            if (!ok || ir_a !== 1'b1 || ov_a !== 1'b0) begin
                bad++;
                $display("FAIL rand_release%0d stable=%0d in_ready=%b out_valid=%b exp 1/1/0",
                         j, ok, ir_a, ov_a);
            end
        end
        or_a = 1;
    endtask

    initial begin
        test_reset();
        test_qr();
        test_vector();
        test_lanes();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chacha_block_core.md
CHACHA_BLOCK_CORE -- requirements
Module: chacha_block_core

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 20, meaning the total quarter-round layers; legal values are 8, 12 and 20.
REQ-002 The block SHALL have parameter LANES, default 4, meaning the quarter-round instances evaluated per cycle; legal values are 1, 2 and 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a job is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the core accepts a job.
REQ-007 The block SHALL have port key, input, 256 bits: word i in bits [32i+31:32i] maps to state word 4+i.
REQ-008 The block SHALL have port counter, input, 32 bits, mapping to state word 12.
REQ-009 The block SHALL have port nonce, input, 96 bits: word j in bits [32j+31:32j] maps to state word 13+j.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the keystream block is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the block.
REQ-012 The block SHALL have port out_block, output, 512 bits: state word k in bits [32k+31:32k].
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 Initial state words 0..3 SHALL be 0x61707865, 0x3320646e, 0x79622d32 and 0x6b206574.
REQ-015 The FSM SHALL have states IDLE, ROUND, FINAL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 An in_valid and in_ready handshake SHALL latch the 16-word initial state into both the working and the saved registers, and SHALL move the FSM from IDLE to ROUND.
REQ-017 Quarter round on (a,b,c,d) SHALL be, all mod 2^32 with left rotates: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
REQ-018 Each step SHALL use the updated values of the preceding step.
REQ-019 Even layers SHALL be column rounds: (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
REQ-020 Odd layers SHALL be diagonal rounds: (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
REQ-021 Each ROUND cycle SHALL apply LANES quarter rounds of the current layer, in lane order 0..3.
REQ-022 A layer SHALL take 4/LANES cycles.
REQ-023 ROUND SHALL last exactly ROUNDS*4/LANES cycles and then go to FINAL, tracked by a layer counter and a lane counter.
REQ-024 FINAL SHALL add the saved initial state to the working state word-wise, mod 2^32, taking 1 cycle, and SHALL then go to DONE.
REQ-025 out_valid SHALL be 1 only in DONE.
REQ-026 out_block SHALL be held stable while out_valid is 1 and out_ready is 0.
REQ-027 DONE with out_ready=1 SHALL go to IDLE; in_ready SHALL rise the next cycle, so there is no same-cycle accept.
REQ-028 Latency SHALL be ROUNDS*4/LANES+1 cycles, measured from the accept edge to the first cycle out_valid is 1.
REQ-029 The latency SHALL be 21 cycles at defaults and 81 cycles at LANES=1, ROUNDS=20.
REQ-030 counter=0xFFFFFFFF SHALL be used unmodified; the core SHALL NOT increment it or carry into the nonce.
REQ-031 Inputs SHALL be sampled only at accept; changes while busy SHALL have no effect.
REQ-032 in_valid while busy SHALL be ignored, and the job SHALL NOT be queued.
REQ-033 out_ready SHALL be ignored outside DONE.
REQ-034 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-035 Asserting rst SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, out_block=0 and counters=0, regardless of state.
REQ-036 A job in progress at reset SHALL be discarded; no out_valid SHALL be produced for it.
REQ-037 After rst deasserts, the first rising edge SHALL be able to accept a job.

Structure
REQ-038 Package chacha_pkg SHALL hold the four constant words, the column and diagonal index tables, the FSM state enumeration, and the 32-bit word typedef.
REQ-039 Sub-module chacha_qr SHALL be a purely combinational quarter round with 4x32 in and 4x32 out, instantiated LANES times.
REQ-040 The working state SHALL be a 16-word register array with lane-indexed write-back.

Verification
REQ-041 Scenario: chacha_qr with a=0x11111111, b=0x01020304, c=0x9b8d6f43, d=0x01234567 -> 0xea2a92f4, 0xcb1cf8ce, 0x4581472e, 0x5881c4bb.
REQ-042 Scenario: key bytes 00..1f, nonce words 0x09000000, 0x4a000000, 0x00000000, counter=1, defaults -> out_block word0=0xe4e7f110, word15=0x4e3c50a2, out_valid after 21 cycles.
REQ-043 Scenario: the same vector for every ROUNDS=20, LANES in {1,2,4} -> identical out_block, with latency 81, 41 and 21 cycles respectively.
REQ-044 Scenario: hold out_ready=0 for 10 cycles in DONE -> out_block is constant, in_ready=0, then the block is released on the first out_ready=1.
REQ-045 Scenario: rst pulse at cycle 7 of ROUND -> out_valid is never asserted; the next job returns the correct result.
REQ-046 Scenario: counter=0xFFFFFFFF with the REQ-042 key and nonce -> out_block matches the software model at counter 0xFFFFFFFF, nonce unchanged; in_valid pulses while busy are ignored.
